// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
// Shared definitions for the up/down modulo counter:
//   WIDTH_DEF / STEP_W_DEF : default counter and step widths
//   dir_e                  : count direction (DIR_DOWN=0, DIR_UP=1)
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int STEP_W_DEF = 4;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/udc_mod_step.sv
// -----------------------------------------------------------------------------
// udc_mod_step
// Combinational modulo add/subtract datapath for up_down_mod_counter.
// Ports:
//   cur      in  WIDTH   current count
//   step     in  STEP_W  step amount
//   limit    in  WIDTH   modulus-1 (range 0..limit)
//   up       in  1       direction (DIR_UP / DIR_DOWN)
//   sat      in  1       saturate instead of wrap (only with
//                        UP_DOWN_MOD_COUNTER_SAT_EN defined)
//   next_val out WIDTH   count after one enabled step
//   wrap     out 1       the step wrapped around the range
//   illegal  out 1       step exceeds limit; count is held
// -----------------------------------------------------------------------------
module udc_mod_step
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STEP_W = STEP_W_DEF
) (
   input  logic [WIDTH-1:0]  cur,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
   input  logic              up,
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
   input  logic              sat,
`endif
   output logic [WIDTH-1:0]  next_val,
   output logic              wrap,
   output logic              illegal
);

   logic             sat_i;
   logic [WIDTH-1:0] step_w;
   logic [WIDTH:0]   sum;

`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
   assign sat_i = sat;
`else
   assign sat_i = 1'b0;
`endif

   assign step_w = WIDTH'(step);
   // One extra bit so an all-ones limit still detects overflow.
   assign sum    = {1'b0, cur} + {1'b0, step_w};

   always_comb begin
      next_val = cur;
      wrap     = 1'b0;
      illegal  = 1'b0;
      if (step_w == '0) begin
         next_val = cur;
      end else if (step_w > limit) begin
         illegal  = 1'b1;
      end else if (cur > limit) begin
         // Limit was lowered beneath the count: snap back into range.
         if (dir_e'(up) == DIR_UP) begin
            next_val = '0;
            wrap     = 1'b1;
         end else begin
            next_val = limit;
         end
      end else if (dir_e'(up) == DIR_UP) begin
         if (sum <= {1'b0, limit}) begin
            next_val = sum[WIDTH-1:0];
         end else if (sat_i) begin
            next_val = limit;
         end else begin
            // Result is below 2^WIDTH, so modular WIDTH-bit math is exact.
            next_val = cur + step_w - limit - 1'b1;
            wrap     = 1'b1;
         end
      end else begin
         if (step_w <= cur) begin
            next_val = cur - step_w;
         end else if (sat_i) begin
            next_val = '0;
         end else begin
            next_val = cur + limit + 1'b1 - step_w;
            wrap     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/up_down_mod_counter.sv
// -----------------------------------------------------------------------------
// up_down_mod_counter
// Up/down counter over 0..limit with variable step, wrap pulse and a sticky
// illegal-operation flag. Optional saturation mode is enabled by defining
// UP_DOWN_MOD_COUNTER_SAT_EN, which adds the sat input.
// Ports:
//   clk       in  1       clock, rising edge
//   reset_n   in  1       asynchronous active-low reset
//   clear     in  1       synchronous clear (q, wrap, err -> 0)
//   load      in  1       synchronous load of load_val (clamped to limit)
//   load_val  in  WIDTH   value to load
//   en        in  1       count enable
//   up        in  1       1 = count up, 0 = count down
//   step      in  STEP_W  count amount
//   limit     in  WIDTH   modulus-1
//   sat       in  1       saturate instead of wrap (macro builds only)
//   q         out WIDTH   registered count
//   wrap      out 1       high in the cycle q holds a wrapped value
//   at_limit  out 1       q == limit
//   at_zero   out 1       q == 0
//   err       out 1       sticky illegal load/step flag
// -----------------------------------------------------------------------------
module up_down_mod_counter
   import up_down_counter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int STEP_W = STEP_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  limit,
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
   input  logic              sat,
`endif
   output logic [WIDTH-1:0]  q,
   output logic              wrap,
   output logic              at_limit,
   output logic              at_zero,
   output logic              err
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] step_next;
   logic             step_wrap;
   logic             step_illegal;

   udc_mod_step #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W)
   ) u_step (
      .cur      (q_q),
      .step     (step),
      .limit    (limit),
      .up       (up),
`ifdef UP_DOWN_MOD_COUNTER_SAT_EN
      .sat      (sat),
`endif
      .next_val (step_next),
      .wrap     (step_wrap),
      .illegal  (step_illegal)
   );

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      err_d  = err_q;
      if (clear) begin
         q_d   = '0;
         err_d = 1'b0;
      end else if (load) begin
         if (load_val > limit) begin
            q_d   = limit;
            err_d = 1'b1;
         end else begin
            q_d = load_val;
         end
      end else if (en) begin
         q_d    = step_next;
         wrap_d = step_wrap;
         err_d  = err_q | step_illegal;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign q        = q_q;
   assign wrap     = wrap_q;
   assign err      = err_q;
   assign at_limit = (q_q == limit);
   assign at_zero  = (q_q == '0);

endmodule
